// File: rtl/fp_addsub_sched.sv
// fp_addsub_sched
//   Round-robin scheduler that time-shares one external combinational
//   floating-point adder/subtractor (add_sub_main) between NUM_REQ requesters.
//   A granted request's operands are registered onto the datapath, held for
//   LAT cycles, then the datapath result is captured and returned with the
//   requester's index over a valid/ready response channel.
//
// Ports
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   req_valid/ready   : per-requester handshake; req_ready is one-hot or zero
//   req_a, req_b      : packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_op            : per-requester operation, 0 = add, 1 = subtract (a-b)
//   dp_a, dp_b, dp_op : registered operands driving add_sub_main
//   dp_result         : combinational result from add_sub_main
//   resp_valid/ready  : response handshake
//   resp_result       : captured datapath result
//   resp_id           : index of the requester owning the response
//   busy              : high whenever the scheduler is not idle
//   op_count          : completed responses, saturating at 0xFFFF
module fp_addsub_sched #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int LAT     = 1,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_op,
  output logic [WIDTH-1:0]         dp_a,
  output logic [WIDTH-1:0]         dp_b,
  output logic                     dp_op,
  input  logic [WIDTH-1:0]         dp_result,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_result,
  output logic [ID_W-1:0]          resp_id,
  output logic                     busy,
  output logic [15:0]              op_count
);

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t             state_reg, state_next;
  logic [ID_W-1:0]    rr_ptr_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   dp_a_reg, dp_b_reg, resp_result_reg;
  logic               dp_op_reg;
  logic [ID_W-1:0]    resp_id_reg;
  logic [15:0]        op_count_reg;

  logic [WIDTH-1:0]   a_arr [NUM_REQ];
  logic [WIDTH-1:0]   b_arr [NUM_REQ];

  logic [2*NUM_REQ-1:0] valid_dbl;
  logic [NUM_REQ-1:0]   valid_rot;
  logic [ID_W-1:0]      offset;
  logic [ID_W:0]        grant_sum;
  logic [ID_W-1:0]      grant_idx;
  logic [ID_W-1:0]      ptr_inc;
  logic                 grant_en;

  // Rotate the valid vector so bit 0 is the requester at rr_ptr; the first
  // set bit of the rotated vector is then the round-robin winner's offset.
  assign valid_dbl = {req_valid, req_valid} >> rr_ptr_reg;
  assign valid_rot = valid_dbl[NUM_REQ-1:0];

  always_comb begin
    offset = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) offset = ID_W'(k);
    end
    grant_sum = {1'b0, rr_ptr_reg} + {1'b0, offset};
    if (grant_sum >= NUM_REQ_W) grant_sum = grant_sum - NUM_REQ_W;
    grant_idx = grant_sum[ID_W-1:0];
    ptr_inc   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  // Grants are suppressed while rst is high so no requester sees an accept
  // that the reset is about to discard.
  assign grant_en = (state_reg == IDLE) && (|req_valid) && !rst;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign a_arr[gi]     = req_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi]     = req_b[gi*WIDTH +: WIDTH];
      assign req_ready[gi] = grant_en && (grant_idx == ID_W'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_en) state_next = BUSY;
      BUSY:    if (cnt_reg == '0) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= '0;
      cnt_reg         <= '0;
      dp_a_reg        <= '0;
      dp_b_reg        <= '0;
      dp_op_reg       <= 1'b0;
      resp_result_reg <= '0;
      resp_id_reg     <= '0;
      op_count_reg    <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          // Operands only move on the grant edge, so the datapath sees
          // stable inputs for the whole BUSY window.
          if (grant_en) begin
            dp_a_reg    <= a_arr[grant_idx];
            dp_b_reg    <= b_arr[grant_idx];
            dp_op_reg   <= req_op[grant_idx];
            resp_id_reg <= grant_idx;
            rr_ptr_reg  <= ptr_inc;
            cnt_reg     <= CNT_W'(LAT - 1);
          end
        end
        BUSY: begin
          if (cnt_reg == '0) resp_result_reg <= dp_result;
          else               cnt_reg         <= cnt_reg - 1'b1;
        end
        RESP: begin
          if (resp_ready && (op_count_reg != 16'hFFFF))
            op_count_reg <= op_count_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dp_a        = dp_a_reg;
  assign dp_b        = dp_b_reg;
  assign dp_op       = dp_op_reg;
  assign resp_valid  = (state_reg == RESP);
  assign resp_result = resp_result_reg;
  assign resp_id     = resp_id_reg;
  assign busy        = (state_reg != IDLE);
  assign op_count    = op_count_reg;

endmodule

// File: tb/tb_fp_addsub_sched.sv
// tb_fp_addsub_sched
//   Bench for fp_addsub_sched. A LAT=1 instance is checked every cycle against
//   a transaction-level model (grant time, round-robin pointer, captured
//   operands); directed sequences pin literal values. A LAT=3 instance gets a
//   directed hold/latency sequence. The add_sub_main stand-in returns exact
//   IEEE results for the directed vectors and a deterministic mix otherwise.
module tb_fp_addsub_sched;
  localparam int W    = 32;
  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int LAT1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // LAT=1 instance signals
  logic           rst, dpop, rsv, rsr, bsy;
  logic [N-1:0]   rv, rr, rop;
  logic [N*W-1:0] ra, rb;
  logic [W-1:0]   dpa, dpb, dpres, rres;
  logic [IDW-1:0] rid;
  logic [15:0]    opc;

  // LAT=3 instance signals
  logic           rst3, dpop3, rsv3, rsr3, bsy3;
  logic [N-1:0]   rv3, rr3, rop3;
  logic [N*W-1:0] ra3, rb3;
  logic [W-1:0]   dpa3, dpb3, dpres3, rres3;
  logic [IDW-1:0] rid3;
  logic [15:0]    opc3;

  function automatic logic [W-1:0] dp_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic op);
    if (a == 32'h3F800000 && b == 32'h40000000 && !op) return 32'h40400000;
    if (a == 32'h40400000 && b == 32'h3F800000 && op)  return 32'h40000000;
    return op ? ((a - b) ^ 32'h5A5A0000) : (a + b);
  endfunction

  assign dpres  = dp_fn(dpa, dpb, dpop);
  assign dpres3 = dp_fn(dpa3, dpb3, dpop3);

  fp_addsub_sched #(.WIDTH(W), .NUM_REQ(N), .LAT(LAT1)) dut (
    .clk(clk), .rst(rst), .req_valid(rv), .req_ready(rr), .req_a(ra), .req_b(rb),
    .req_op(rop), .dp_a(dpa), .dp_b(dpb), .dp_op(dpop), .dp_result(dpres),
    .resp_valid(rsv), .resp_ready(rsr), .resp_result(rres), .resp_id(rid),
    .busy(bsy), .op_count(opc)
  );

  fp_addsub_sched #(.WIDTH(W), .NUM_REQ(N), .LAT(3)) dut3 (
    .clk(clk), .rst(rst3), .req_valid(rv3), .req_ready(rr3), .req_a(ra3), .req_b(rb3),
    .req_op(rop3), .dp_a(dpa3), .dp_b(dpb3), .dp_op(dpop3), .dp_result(dpres3),
    .resp_valid(rsv3), .resp_ready(rsr3), .resp_result(rres3), .resp_id(rid3),
    .busy(bsy3), .op_count(opc3)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model of the LAT=1 instance ----------
  bit           m_valid = 0;
  bit           m_act   = 0;
  int           m_t, m_ptr, m_id, m_cnt;
  logic [W-1:0] m_a, m_b, m_res;
  logic         m_op;

  always @(negedge clk) begin
    int           g;
    logic [N-1:0] exp_rdy;
    g       = -1;
    exp_rdy = '0;
    if (!m_act && !rst) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && rv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;

    if (m_valid) begin
      chk("m_req_ready", rr, exp_rdy);
      chk("m_busy", bsy, m_act);
      chk("m_resp_valid", rsv, m_act && (m_t > LAT1));
      chk("m_dp_a", dpa, m_a);
      chk("m_dp_b", dpb, m_b);
      chk("m_dp_op", dpop, m_op);
      chk("m_resp_result", rres, m_res);
      chk("m_resp_id", rid, m_id);
      chk("m_op_count", opc, m_cnt);
    end

    // Advance the model across the coming rising edge.
    if (rst) begin
      m_valid = 1; m_act = 0; m_t = 0; m_ptr = 0; m_id = 0; m_cnt = 0;
      m_a = '0; m_b = '0; m_op = 1'b0; m_res = '0;
    end else if (!m_act) begin
      if (g >= 0) begin
        m_act = 1; m_t = 1; m_id = g; m_ptr = (g + 1) % N;
        m_a = ra[g*W +: W]; m_b = rb[g*W +: W]; m_op = rop[g];
      end
    end else if (m_t <= LAT1) begin
      if (m_t == LAT1) m_res = dp_fn(m_a, m_b, m_op);
      m_t++;
    end else if (rsr) begin
      m_act = 0;
      if (m_cnt < 65535) m_cnt++;
    end
  end

  // ---------------- helpers ------------------------------------------------
  task automatic wait_resp(input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (rsv) begin
        ok = 1;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus -----------------------------------------------
  int           t0, grants, last, idx;
  bit           ok;
  logic [N-1:0] gr;

  initial begin
    rst = 1'b1; rv = '0; ra = '0; rb = '0; rop = '0; rsr = 1'b1;
    rst3 = 1'b1; rv3 = '0; ra3 = '0; rb3 = '0; rop3 = '0; rsr3 = 1'b1;

    // Reset with a valid request pending: no grant may be issued.
    rv = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_req_ready", rr, 4'b0000);
    chk("rst_busy", bsy, 0);
    chk("rst_resp_valid", rsv, 0);
    chk("rst_op_count", opc, 0);
    chk("rst_dp_a", dpa, 0);
    chk("rst3_busy", bsy3, 0);
    @(posedge clk); #1;
    rst = 1'b0; rst3 = 1'b0;

    // Single add on requester 0.
    ra[0*W +: W] = 32'h3F800000; rb[0*W +: W] = 32'h40000000; rop[0] = 1'b0;
    rv = 4'b0001;
    @(negedge clk);
    chk("add_grant", rr, 4'b0001);
    t0 = cyc;
    @(posedge clk); #1;
    rv = '0;
    wait_resp(10, ok);
    chk("add_timeout", ok, 1);
    chk("add_latency", cyc - t0, 2);
    chk("add_result", rres, 32'h40400000);
    chk("add_id", rid, 0);
    @(posedge clk); #1;

    // Subtract on requester 2.
    ra[2*W +: W] = 32'h40400000; rb[2*W +: W] = 32'h3F800000; rop[2] = 1'b1;
    rv = 4'b0100;
    @(negedge clk);
    chk("sub_grant", rr, 4'b0100);
    @(posedge clk); #1;
    rv = '0;
    wait_resp(10, ok);
    chk("sub_timeout", ok, 1);
    chk("sub_result", rres, 32'h40000000);
    chk("sub_id", rid, 2);
    @(posedge clk); #1;

    // Mid-operation reset: rr_ptr is 3 before the reset, 0 after it.
    rv = 4'b0100;
    @(negedge clk);
    chk("mrst_grant", rr, 4'b0100);
    @(posedge clk); #1;
    rv = '0; rst = 1'b1;
    @(negedge clk);
    chk("mrst_busy_before", bsy, 1);
    @(posedge clk); #1;
    rst = 1'b0; rv = 4'b1010;
    @(negedge clk);
    chk("mrst_busy_after", bsy, 0);
    chk("mrst_resp_valid", rsv, 0);
    chk("mrst_op_count", opc, 0);
    chk("mrst_dp_a", dpa, 0);
    chk("mrst_next_grant", rr, 4'b0010);
    @(posedge clk); #1;
    rv = '0;
    wait_resp(10, ok);
    chk("mrst_timeout", ok, 1);
    chk("mrst_id", rid, 1);
    @(posedge clk); #1;

    // Fairness: all requesters continuously valid from rr_ptr = 0.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      ra[i*W +: W] = $urandom; rb[i*W +: W] = $urandom; rop[i] = 1'($urandom_range(0, 1));
    end
    rv = 4'b1111; rsr = 1'b1;
    grants = 0; last = 0;
    for (int i = 0; i < 60 && grants < 8; i++) begin
      @(negedge clk);
      if (rr != '0) begin
        idx = oh2i(rr);
        chk("fair_onehot", $countones(rr), 1);
        chk("fair_order", idx, grants % N);
        if (grants > 0) chk("fair_gap", cyc - last, LAT1 + 2);
        last = cyc;
        grants++;
      end
      @(posedge clk); #1;
      if (grants == 8) rv = '0;
    end
    chk("fair_grants", grants, 8);
    wait_resp(10, ok);
    chk("fair_timeout", ok, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("fair_op_count", opc, 8);
    @(posedge clk); #1;

    // Backpressure: response held for 10 cycles with other requests pending.
    rsr = 1'b0;
    ra[1*W +: W] = 32'h12345678; rb[1*W +: W] = 32'h01010101; rop[1] = 1'b0;
    rv = 4'b0010;
    @(negedge clk);
    chk("bp_grant", rr, 4'b0010);
    @(posedge clk); #1;
    rv = 4'b1111;
    wait_resp(10, ok);
    chk("bp_timeout", ok, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_valid", rsv, 1);
      chk("bp_result", rres, 32'h13355779);
      chk("bp_id", rid, 1);
      chk("bp_no_grant", rr, 4'b0000);
    end
    @(posedge clk); #1;
    rsr = 1'b1; rv = '0;
    @(negedge clk);
    chk("bp_valid_last", rsv, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_released", rsv, 0);
    chk("bp_op_count", opc, 9);

    // Randomized traffic with hold-until-ready requesters and rare resets.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      gr = rr;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (!(rv[i] && !gr[i] && $urandom_range(0, 19) != 0)) begin
          rv[i]        = ($urandom_range(0, 2) == 0);
          ra[i*W +: W] = $urandom;
          rb[i*W +: W] = $urandom;
          rop[i]       = 1'($urandom_range(0, 1));
        end
      end
      rsr = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
    end
    rst = 1'b0; rv = '0; rsr = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // LAT=3 instance: operands held through three BUSY cycles.
    ra3[3*W +: W] = 32'h3F800000; rb3[3*W +: W] = 32'h40000000; rop3[3] = 1'b0;
    rv3 = 4'b1000; rsr3 = 1'b1;
    @(negedge clk);
    chk("l3_grant", rr3, 4'b1000);
    t0 = cyc;
    @(posedge clk); #1;
    rv3 = '0; ra3[3*W +: W] = 32'hFFFFFFFF; rop3[3] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("l3_busy", bsy3, 1);
      chk("l3_no_resp", rsv3, 0);
      chk("l3_dp_a", dpa3, 32'h3F800000);
      chk("l3_dp_b", dpb3, 32'h40000000);
      chk("l3_dp_op", dpop3, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("l3_resp_valid", rsv3, 1);
    chk("l3_latency", cyc - t0, 4);
    chk("l3_result", rres3, 32'h40400000);
    chk("l3_id", rid3, 3);
    @(posedge clk); #1;
    @(negedge clk);
    chk("l3_released", rsv3, 0);
    chk("l3_op_count", opc3, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
